comm_master: RTL and testbench
==============================

COMM_MASTER -- requirements
Module: comm_master

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 2604, meaning clk cycles per UART bit (50 MHz clk, 19200 baud).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic rising-edge triggered.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port RX, input, 1, serial data from the copter, asynchronous.
REQ-005 SHALL have port TX, output, 1, serial data to the copter.
REQ-006 SHALL have port cmd, input, 8, command opcode to send.
REQ-007 SHALL have port data, input, 16, payload sent with the command.
REQ-008 SHALL have port snd_cmd, input, 1, one-cycle pulse that starts a frame.
REQ-009 SHALL have port frm_snt, output, 1, high once the last frame's final stop bit completes.
REQ-010 SHALL have port resp, output, 8, last byte received.
REQ-011 SHALL have port resp_rdy, output, 1, high while resp holds an unconsumed byte.
REQ-012 SHALL have port clr_resp_rdy, input, 1, pulse that knocks down resp_rdy.

Function
REQ-013 SHALL frame bytes as 8N1: start bit 0, 8 data bits LSB first, one stop bit 1, each bit exactly BAUD_DIV cycles.
REQ-014 SHALL send each frame as three bytes in order: cmd, data[15:8], data[7:0], with no idle gap between them.
REQ-015 SHALL latch cmd and data on the snd_cmd cycle; input changes during a frame SHALL NOT affect it.
REQ-016 SHALL use a TX FSM with states IDLE -> SEND_CMD -> SEND_HI -> SEND_LO -> IDLE; each state advances only after its byte's stop bit completes.
REQ-017 SHALL clear frm_snt on the cycle after snd_cmd is accepted, and set it in the cycle SEND_LO's stop bit ends.
REQ-018 SHALL hold frm_snt set until the next accepted snd_cmd.
REQ-019 SHALL ignore snd_cmd while the FSM is not IDLE.
REQ-020 SHALL drive TX high in IDLE and between frames.
REQ-021 SHALL double-flop RX before any use.
REQ-022 SHALL detect a start bit on a falling edge of the synchronized RX.
REQ-023 SHALL sample each received bit at its midpoint (BAUD_DIV/2 after the bit edge).
REQ-024 SHALL abandon a start bit that reads 1 at its midpoint and return to receive-idle.
REQ-025 SHALL load resp and set resp_rdy in the cycle the stop-bit midpoint is sampled; resp SHALL be unchanged until the next complete byte.
REQ-026 SHALL clear resp_rdy on clr_resp_rdy or on detection of a new start bit.
REQ-027 SHALL let set win when resp_rdy set and clear occur in the same cycle.
REQ-028 SHALL run the transmitter and receiver fully independently (full duplex).

Reset
REQ-029 SHALL, on rst high at a clk edge, force TX=1, frm_snt=0, resp=0x00, resp_rdy=0, both FSMs idle, and all counters to 0.
REQ-030 SHALL abort any frame in progress when rst is asserted mid-frame, with TX going high the next cycle.

Configuration
REQ-031 SHALL use macro COMM_MASTER_RESP_AUTOCLR_EN: when defined, an accepted snd_cmd also clears resp_rdy (same priority as clr_resp_rdy); when undefined, only REQ-026 clears resp_rdy.

Verification
REQ-032 SHALL cover: snd_cmd with cmd=0x05, data=0x01FF -> TX carries bytes 0x05, 0x01, 0xFF, LSB first, 8N1; frm_snt rises after 30*BAUD_DIV cycles.
REQ-033 SHALL cover: loopback of TX into a UART slave that replies 0xA5 -> resp=0xA5 and resp_rdy=1; clr_resp_rdy pulse -> resp_rdy=0, resp still 0xA5.
REQ-034 SHALL cover: second snd_cmd (cmd=0x07, data=0x0000) mid-frame -> ignored; frame continues unchanged; frm_snt still rises once.
REQ-035 SHALL cover: a 0.25-bit low glitch on RX -> no byte received; resp_rdy stays 0.
REQ-036 SHALL cover: rst pulsed during the SEND_HI byte -> TX=1 next cycle and frm_snt=0; a fresh snd_cmd then sends a complete frame.
REQ-037 SHALL cover: clr_resp_rdy in the same cycle as a stop-bit sample -> resp_rdy=1 with the new byte.

Source files
------------

// File: rtl/comm_master.sv
// ---------------------------------------------------------------------------
// comm_master
//   Full-duplex UART master for the copter link. A pulse on snd_cmd latches
//   an 8-bit opcode and a 16-bit payload and transmits them as three
//   back-to-back 8N1 bytes (cmd, data[15:8], data[7:0]). Independently, the
//   receiver collects bytes arriving on RX and presents the most recent one
//   on resp, flagged by resp_rdy.
//
// Parameters
//   BAUD_DIV      clk cycles per UART bit (default 2604: 50 MHz / 19200 baud).
//                 Must be at least 4.
//
// Ports
//   clk           single clock, rising-edge
//   rst           synchronous active-high reset
//   RX            serial data from the copter (asynchronous)
//   TX            serial data to the copter (idles high)
//   cmd           command opcode to send
//   data          16-bit payload sent after cmd, high byte first
//   snd_cmd       one-cycle pulse that starts a frame (ignored while busy)
//   frm_snt       high once the last frame's final stop bit has completed
//   resp          last byte received
//   resp_rdy      high while resp holds an unconsumed byte
//   clr_resp_rdy  pulse that knocks down resp_rdy
//
// Configuration macro
//   COMM_MASTER_RESP_AUTOCLR_EN  when defined, an accepted snd_cmd also
//                                clears resp_rdy (same priority as
//                                clr_resp_rdy).
// ---------------------------------------------------------------------------
module comm_master #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        snd_cmd,
  output logic        frm_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam int            CW        = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  // Bit positions within one 10-bit 8N1 frame: 0 = start, 1..8 = data, 9 = stop.
  localparam logic [3:0]    STOP_IDX  = 4'd9;

  typedef enum logic [1:0] {IDLE, SEND_CMD, SEND_HI, SEND_LO} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // -------------------------------------------------------------------------
  // Transmitter
  // -------------------------------------------------------------------------
  tx_state_t     tx_state;
  tx_state_t     tx_state_nxt;
  logic [CW-1:0] tx_baud;
  logic [3:0]    tx_bit;
  logic [3:0]    tx_bit_nxt;
  logic [7:0]    cmd_q;
  logic [15:0]   data_q;
  logic [7:0]    tx_byte;
  logic [9:0]    tx_frame;
  logic          tx_accept;
  logic          tx_bit_end;
  logic          tx_byte_end;

  // Byte currently on the wire, chosen by which of the three bytes we are in.
  always_comb begin
    tx_byte = data_q[7:0];
    case (tx_state)
      SEND_CMD: tx_byte = cmd_q;
      SEND_HI:  tx_byte = data_q[15:8];
      default:  tx_byte = data_q[7:0];
    endcase
  end

  assign tx_frame   = {1'b1, tx_byte, 1'b0};
  assign tx_bit_nxt = tx_bit + 4'd1;

  // TX next-state logic: each byte state advances only when its stop bit
  // has been on the line for a full bit period.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_accept    = 1'b0;
    tx_bit_end   = (tx_state != IDLE) && (tx_baud == BIT_LAST);
    tx_byte_end  = tx_bit_end && (tx_bit == STOP_IDX);
    case (tx_state)
      IDLE: begin
        if (snd_cmd) begin
          tx_accept    = 1'b1;
          tx_state_nxt = SEND_CMD;
        end
      end
      SEND_CMD: if (tx_byte_end) tx_state_nxt = SEND_HI;
      SEND_HI:  if (tx_byte_end) tx_state_nxt = SEND_LO;
      SEND_LO:  if (tx_byte_end) tx_state_nxt = IDLE;
      default:  tx_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) tx_state <= IDLE;
    else     tx_state <= tx_state_nxt;
  end

  // TX datapath. TX is registered so the line never glitches; the value for
  // the next bit is loaded on the edge that ends the current one. Going
  // straight from a stop bit to the next start bit gives the gap-free
  // three-byte burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_baud <= '0;
      tx_bit  <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
      TX      <= 1'b1;
      frm_snt <= 1'b0;
    end else if (tx_accept) begin
      cmd_q   <= cmd;
      data_q  <= data;
      tx_baud <= '0;
      tx_bit  <= '0;
      TX      <= 1'b0;
      frm_snt <= 1'b0;
    end else if (tx_state != IDLE) begin
      if (tx_bit_end) begin
        tx_baud <= '0;
        if (tx_byte_end) begin
          tx_bit <= '0;
          if (tx_state == SEND_LO) begin
            TX      <= 1'b1;
            frm_snt <= 1'b1;
          end else begin
            TX <= 1'b0;
          end
        end else begin
          tx_bit <= tx_bit_nxt;
          TX     <= tx_frame[tx_bit_nxt];
        end
      end else begin
        tx_baud <= tx_baud + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Receiver
  // -------------------------------------------------------------------------
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  logic          rx_fall;
  rx_state_t     rx_state;
  rx_state_t     rx_state_nxt;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_start_det;
  logic          rx_load;
  logic          auto_clr;
  logic          resp_clr;

  // Two-flop synchronizer for the asynchronous RX line, plus one more stage
  // of history for falling-edge detection. All reset to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // RX next-state logic. The start bit is re-checked half a bit after the
  // falling edge so short glitches fall back to idle; every later bit is
  // then sampled one full bit period after the previous midpoint.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_start_det = 1'b0;
    rx_load      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_start_det = 1'b1;
          rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if ((rx_cnt == BIT_LAST) && (rx_bit == 3'd7)) rx_state_nxt = RX_STOP;
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_load      = 1'b1;
          rx_state_nxt = RX_IDLE;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_state_nxt;
  end

`ifdef COMM_MASTER_RESP_AUTOCLR_EN
  assign auto_clr = tx_accept;
`else
  assign auto_clr = 1'b0;
`endif

  assign resp_clr = clr_resp_rdy | rx_start_det | auto_clr;

  // RX datapath: baud counter, bit counter and LSB-first shift register.
  // resp is only written when a whole byte has arrived. For resp_rdy a new
  // byte landing beats any clear request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      resp     <= '0;
      resp_rdy <= 1'b0;
    end else begin
      case (rx_state)
        RX_START: begin
          if (rx_cnt == HALF_LAST) rx_cnt <= '0;
          else                     rx_cnt <= rx_cnt + 1'b1;
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) rx_cnt <= '0;
          else                    rx_cnt <= rx_cnt + 1'b1;
        end
        default: begin
          rx_cnt <= '0;
          rx_bit <= '0;
        end
      endcase

      if (rx_load) resp <= rx_shift;

      if (rx_load)       resp_rdy <= 1'b1;
      else if (resp_clr) resp_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_comm_master.sv
// ---------------------------------------------------------------------------
// tb_comm_master
//   Self-checking bench for comm_master. The expected TX waveform is built
//   from the byte list of each frame; a behavioural UART slave drives RX and
//   the bench tracks what resp/resp_rdy should hold after each event.
// ---------------------------------------------------------------------------
module tb_comm_master;

  localparam int BAUD      = 16;
  localparam int FRAME_CYC = 30 * BAUD;

  logic        clk = 1'b0;
  logic        rst;
  logic        RX;
  logic        TX;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        snd_cmd;
  logic        frm_snt;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy;

  int          errors = 0;
  int          checks = 0;
  logic        modelRdy;
  logic [7:0]  modelResp;
  bit          saw;
  logic [7:0]  rc;
  logic [15:0] rd;
  logic [7:0]  rr;
  logic [29:0] rstExp;

  always #5 clk = ~clk;

  comm_master #(.BAUD_DIV(BAUD)) dut (
    .clk          (clk),
    .rst          (rst),
    .RX           (RX),
    .TX           (TX),
    .cmd          (cmd),
    .data         (data),
    .snd_cmd      (snd_cmd),
    .frm_snt      (frm_snt),
    .resp         (resp),
    .resp_rdy     (resp_rdy),
    .clr_resp_rdy (clr_resp_rdy)
  );

  // Keeps a broken design from hanging the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Serial bit sequence of a frame: three 8N1 bytes, LSB first, bit 0 first.
  function automatic logic [29:0] frameBits(input logic [7:0] c, input logic [15:0] d);
    logic [29:0] v;
    logic [7:0]  by;
    v = '0;
    for (int b = 0; b < 3; b++) begin
      by = (b == 0) ? c : ((b == 1) ? d[15:8] : d[7:0]);
      v[b*10] = 1'b0;
      for (int i = 0; i < 8; i++) v[b*10+1+i] = by[i];
      v[b*10+9] = 1'b1;
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic applyStimulus(input logic [7:0] c, input logic [15:0] d);
    cmd     = c;
    data    = d;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
  endtask

  // Sends one frame and checks every TX cycle, the mid-bit values and the
  // frm_snt timing. Optionally scrambles cmd/data and pulses a second
  // snd_cmd (0x07/0x0000) at cycle intrudeAt of the frame.
  task automatic runFrame(input logic [7:0] c, input logic [15:0] d,
                          input bit scramble, input int intrudeAt);
    logic [29:0] expv;
    logic [29:0] midv;
    int          waveErr;
    int          early;
    int          idleLow;
    expv    = frameBits(c, d);
    midv    = '0;
    waveErr = 0;
    early   = 0;
    idleLow = 0;
    applyStimulus(c, d);
`ifdef COMM_MASTER_RESP_AUTOCLR_EN
    modelRdy = 1'b0;
`endif
    checkOutput("frm_snt_cleared", {31'd0, frm_snt}, 32'd0);
    for (int t = 0; t < FRAME_CYC; t++) begin
      if (TX !== expv[t/BAUD]) waveErr++;
      if ((t % BAUD) == BAUD/2) midv[t/BAUD] = TX;
      if (frm_snt !== 1'b0) early++;
      snd_cmd = (t == intrudeAt);
      if (t == intrudeAt) begin
        cmd  = 8'h07;
        data = 16'h0000;
      end else if (scramble) begin
        cmd  = 8'($urandom);
        data = 16'($urandom);
      end
      @(negedge clk);
    end
    snd_cmd = 1'b0;
    checkOutput("tx_mid_bits", {2'b00, midv}, {2'b00, expv});
    checkOutput("tx_wave_errs", waveErr, 0);
    checkOutput("frm_snt_early", early, 0);
    checkOutput("frm_snt_set", {31'd0, frm_snt}, 32'd1);
    for (int k = 0; k < 3*BAUD; k++) begin
      @(negedge clk);
      if (TX !== 1'b1) idleLow++;
    end
    checkOutput("tx_idle_low_cycles", idleLow, 0);
    checkOutput("frm_snt_hold", {31'd0, frm_snt}, 32'd1);
    checkOutput("frame_resp", {24'd0, resp}, {24'd0, modelResp});
    checkOutput("frame_resp_rdy", {31'd0, resp_rdy}, {31'd0, modelRdy});
  endtask

  // Behavioural UART slave driving RX. With clrAtStop, clr_resp_rdy is held
  // high through the stop bit and dropped only after resp_rdy is seen high,
  // so it is certainly asserted on the edge where the byte lands.
  task automatic uartSend(input logic [7:0] b, input bit clrAtStop, output bit sawSet);
    sawSet   = 1'b0;
    RX       = 1'b0;
    modelRdy = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = 1'b1;
    if (clrAtStop) clr_resp_rdy = 1'b1;
    for (int k = 0; k < BAUD + 8; k++) begin
      @(negedge clk);
      if (clrAtStop && clr_resp_rdy && (resp_rdy === 1'b1)) begin
        clr_resp_rdy = 1'b0;
        sawSet       = 1'b1;
      end
    end
    clr_resp_rdy = 1'b0;
    modelRdy     = 1'b1;
    modelResp    = b;
  endtask

  initial begin
    rst          = 1'b1;
    RX           = 1'b1;
    cmd          = '0;
    data         = '0;
    snd_cmd      = 1'b0;
    clr_resp_rdy = 1'b0;
    modelRdy     = 1'b0;
    modelResp    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", {31'd0, TX}, 32'd1);
    checkOutput("rst_frm_snt", {31'd0, frm_snt}, 32'd0);
    checkOutput("rst_resp", {24'd0, resp}, 32'd0);
    checkOutput("rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Directed frame 0x05 / 0x01FF
    $display("[TB] frame 05/01FF");
    runFrame(8'h05, 16'h01FF, 1'b0, -1);

    // Slave replies 0xA5, then the byte is consumed
    $display("[TB] slave reply A5");
    uartSend(8'hA5, 1'b0, saw);
    checkOutput("rx_resp_a5", {24'd0, resp}, 32'h0000_00A5);
    checkOutput("rx_rdy_a5", {31'd0, resp_rdy}, 32'd1);
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
    modelRdy     = 1'b0;
    checkOutput("clr_rdy", {31'd0, resp_rdy}, 32'd0);
    checkOutput("clr_resp_kept", {24'd0, resp}, 32'h0000_00A5);

    // Second snd_cmd mid-frame plus input churn must not disturb the frame
    $display("[TB] mid-frame snd_cmd");
    runFrame(8'h3C, 16'hBEEF, 1'b1, 100);

    // Quarter-bit glitch on RX
    $display("[TB] RX glitch");
    RX = 1'b0;
    repeat (BAUD/4) @(negedge clk);
    RX       = 1'b1;
    modelRdy = 1'b0;
    repeat (12*BAUD) @(negedge clk);
    checkOutput("glitch_rdy", {31'd0, resp_rdy}, {31'd0, modelRdy});
    checkOutput("glitch_resp", {24'd0, resp}, {24'd0, modelResp});

    // Clear in the same cycle as the stop-bit sample: set wins
    $display("[TB] clear vs set");
    uartSend(8'h5A, 1'b1, saw);
    checkOutput("clr_vs_set_seen", {31'd0, saw}, 32'd1);
    checkOutput("clr_vs_set_rdy", {31'd0, resp_rdy}, 32'd1);
    checkOutput("clr_vs_set_resp", {24'd0, resp}, 32'h0000_005A);

    // A frame with an unconsumed byte pending (auto-clear build dependent)
    rc = 8'($urandom);
    rd = 16'($urandom);
    runFrame(rc, rd, 1'b0, -1);

    // Reset during the start bit of the high data byte
    $display("[TB] reset mid-frame");
    rstExp = frameBits(8'h11, 16'h2233);
    applyStimulus(8'h11, 16'h2233);
    repeat (165) @(negedge clk);
    checkOutput("pre_rst_tx", {31'd0, TX}, {31'd0, rstExp[165/BAUD]});
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_tx", {31'd0, TX}, 32'd1);
    checkOutput("mid_rst_frm_snt", {31'd0, frm_snt}, 32'd0);
    checkOutput("mid_rst_rdy", {31'd0, resp_rdy}, 32'd0);
    rst       = 1'b0;
    modelRdy  = 1'b0;
    modelResp = '0;
    @(negedge clk);
    checkOutput("post_rst_resp", {24'd0, resp}, 32'd0);
    runFrame(8'hC3, 16'h9A5F, 1'b0, -1);

    // Random full-duplex traffic
    $display("[TB] random duplex");
    for (int n = 0; n < 3; n++) begin
      rc = 8'($urandom);
      rd = 16'($urandom);
      rr = 8'($urandom);
      fork
        runFrame(rc, rd, 1'b1, -1);
        begin
          repeat (50 + $urandom_range(0, 40)) @(negedge clk);
          uartSend(rr, 1'b0, saw);
        end
      join
      checkOutput("duplex_resp", {24'd0, resp}, {24'd0, rr});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
